multi_rate_scaler: RTL and testbench
====================================

# multi_rate_scaler

Parametrised multi-channel clock scaler producing independent divided waveforms from one system clock. Each channel has its own divisor, duty value and mode (toggle, strobe, PWM, one-shot), all programmable at run time through a single-cycle write port with glitch-free shadow update at period boundaries. It sits next to the system clock in the design and feeds slow enables, LED and display refresh strobes, and PWM drives.

## Interface
Parameters:
- CHANNELS, 4, number of independent channels (1..16)
- WIDTH, 26, counter, divisor and duty width
- CH_W, $clog2(CHANNELS) min 1, channel-select width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  CHANNELS  per-channel run enable
- sync  in  1  global restart of all channels
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_W  channel to write
- cfg_mode  in  2  0 TOGGLE, 1 STROBE, 2 PWM, 3 ONESHOT
- cfg_div  in  WIDTH  period minus one
- cfg_duty  in  WIDTH  PWM high-cycle count
- out  out  CHANNELS  scaled waveform, registered
- tick  out  CHANNELS  one-cycle period-end strobe, registered

## Operation
- Reset: counters 0, out 0, tick 0; active and shadow div = all-ones, duty 0, mode TOGGLE; ONESHOT armed.
- Counter counts 0..div inclusive; period = div+1 cycles. Wrap when counter == div: counter <= 0.
- tick[i] <= 1 on the edge that samples counter == div (all modes while running), else 0.
- TOGGLE: out inverts at each wrap; output period 2*(div+1).
- STROBE: out identical to tick.
- PWM: out <= (counter_next < duty); duty 0 gives constant 0, duty > div gives constant 1.
- ONESHOT: counts once from en rising; at wrap, tick = out = 1 for one cycle, then channel holds counter 0, out 0 until en drops and rises again.
- Config: cfg_we writes cfg_mode/div/duty to channel cfg_ch shadow registers; cfg_ch >= CHANNELS ignored. Shadow copies to active at wrap, or every cycle while en[i] = 0. Write on a wrap cycle lands in shadow and applies at the next wrap.
- en[i] = 0: counter held 0, out 0, tick 0. Disable mid-period discards the partial period.
- sync: all counters 0, all shadows loaded into active, out 0, tick 0, ONESHOT re-armed; sync overrides a coincident wrap and tick.
- div = 0: TOGGLE toggles every cycle; STROBE and tick constant 1 while enabled.

## Timing
- First tick after the (div+1)th rising edge with en sampled high; subsequent ticks every div+1 cycles.
- cfg write to enabled channel: effect no earlier than the next wrap. To disabled channel: active after 1 edge.
- sync: effect on the next edge; counting resumes the following edge.
- No combinational path from any input to out or tick.

## Structure
- Package scaler_pkg: mode localparams (MODE_TOGGLE, MODE_STROBE, MODE_PWM, MODE_ONESHOT), mode width constant.
- Sub-module scaler_channel: one counter, shadow/active registers, mode logic and ONESHOT arm flag; top instantiates CHANNELS copies in a generate loop and decodes cfg_we/cfg_ch to per-channel write enables.

## Test plan
- Reset, write ch0 TOGGLE div=3, en[0]=1 -> tick every 4 cycles, out period 8 cycles, first tick after 4th edge.
- ch1 PWM div=9 duty=3 -> out high 3, low 7, repeating; duty=0 -> constant 0; duty=12 -> constant 1.
- ch2 running div=7, write div=1 mid-period -> current period completes at 8 cycles, then period 2.
- ch3 ONESHOT div=5, en held high -> single tick/out pulse 6 cycles after enable, none after; en low-high -> one more pulse.
- sync asserted on a ch0 wrap cycle -> no tick, all out 0, all channels restart aligned with identical tick phase.
- cfg_ch = CHANNELS (CHANNELS=4 -> cfg_ch 4 unreachable; run with CHANNELS=3, cfg_ch=3) -> no channel changes; async rst mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared constants for the multi-rate scaler: channel mode encodings.
package scaler_pkg;
    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_TOGGLE  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_STROBE  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_PWM     = 2'd2;
    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd3;
endpackage

// File: rtl/multi_rate_scaler_if.sv
// Control, configuration and waveform bundle between a scaler and its user.
interface multi_rate_scaler_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 26,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    import scaler_pkg::*;

    logic [CHANNELS-1:0] en;
    logic                sync;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [MODE_W-1:0]   cfg_mode;
    logic [WIDTH-1:0]    cfg_div;
    logic [WIDTH-1:0]    cfg_duty;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] tick;

    modport master (
        output en, sync, cfg_we, cfg_ch, cfg_mode, cfg_div, cfg_duty,
        input  out, tick
    );

    modport slave (
        input  en, sync, cfg_we, cfg_ch, cfg_mode, cfg_div, cfg_duty,
        output out, tick
    );
endinterface

// File: rtl/scaler_channel.sv
// One scaler channel: period counter, shadow/active config and mode output logic.
module scaler_channel
    import scaler_pkg::*;
#(
    parameter int unsigned WIDTH = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic              we_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  div_i,
    input  logic [WIDTH-1:0]  duty_i,
    output logic              out_o,
    output logic              tick_o
);
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  act_div_q, act_div_d, act_duty_q, act_duty_d;
    logic [MODE_W-1:0] act_mode_q, act_mode_d;
    logic [WIDTH-1:0]  sh_div_q, sh_div_d, sh_duty_q, sh_duty_d;
    logic [MODE_W-1:0] sh_mode_q, sh_mode_d;
    logic              out_q, out_d, tick_q, tick_d, armed_q, armed_d;
    logic              wrap_c;
    logic [WIDTH-1:0]  cnt_nxt_c;

    assign wrap_c    = (cnt_q == act_div_q);
    assign cnt_nxt_c = wrap_c ? '0 : cnt_q + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            act_div_q  <= '1;
            act_duty_q <= '0;
            act_mode_q <= MODE_TOGGLE;
            sh_div_q   <= '1;
            sh_duty_q  <= '0;
            sh_mode_q  <= MODE_TOGGLE;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            act_duty_q <= act_duty_d;
            act_mode_q <= act_mode_d;
            sh_div_q   <= sh_div_d;
            sh_duty_q  <= sh_duty_d;
            sh_mode_q  <= sh_mode_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        act_duty_d = act_duty_q;
        act_mode_d = act_mode_q;
        sh_div_d   = sh_div_q;
        sh_duty_d  = sh_duty_q;
        sh_mode_d  = sh_mode_q;
        out_d      = out_q;
        tick_d     = 1'b0;
        armed_d    = armed_q;

        if (we_i) begin
            sh_div_d  = div_i;
            sh_duty_d = duty_i;
            sh_mode_d = mode_i;
        end

        // Idle or restart: park the channel and keep active tracking the shadow.
        if (sync_i || !en_i) begin
            cnt_d      = '0;
            out_d      = 1'b0;
            armed_d    = 1'b1;
            act_div_d  = sh_div_q;
            act_duty_d = sh_duty_q;
            act_mode_d = sh_mode_q;
        end else if (act_mode_q == MODE_ONESHOT && !armed_q) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else begin
            cnt_d  = cnt_nxt_c;
            tick_d = wrap_c;
            if (wrap_c) begin
                act_div_d  = sh_div_q;
                act_duty_d = sh_duty_q;
                act_mode_d = sh_mode_q;
            end
            case (act_mode_q)
                MODE_TOGGLE: out_d = out_q ^ wrap_c;
                MODE_STROBE: out_d = wrap_c;
                MODE_PWM:    out_d = (cnt_nxt_c < act_duty_q);
                default: begin
                    out_d   = wrap_c;
                    armed_d = !wrap_c;
                end
            endcase
        end
    end

    assign out_o  = out_q;
    assign tick_o = tick_q;
endmodule

// File: rtl/multi_rate_scaler.sv
// Multi-channel clock scaler: decodes config writes and replicates scaler_channel.
module multi_rate_scaler #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 26
) (
    input logic               clk,
    input logic               rst,
    multi_rate_scaler_if.slave bus
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] we_c;
    logic [CHANNELS-1:0] out_w;
    logic [CHANNELS-1:0] tick_w;

    // Out-of-range channel selects match no bit and are dropped.
    always_comb begin
        we_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            we_c[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        scaler_channel #(.WIDTH(WIDTH)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en_i   (bus.en[i]),
            .sync_i (bus.sync),
            .we_i   (we_c[i]),
            .mode_i (bus.cfg_mode),
            .div_i  (bus.cfg_div),
            .duty_i (bus.cfg_duty),
            .out_o  (out_w[i]),
            .tick_o (tick_w[i])
        );
    end

    assign bus.out  = out_w;
    assign bus.tick = tick_w;
endmodule

// File: tb/tb_multi_rate_scaler.sv
// Self-checking bench for multi_rate_scaler: closed-form waveform expectations via a scoreboard queue.
module tb_multi_rate_scaler;
    import scaler_pkg::*;

    localparam int unsigned W = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multi_rate_scaler_if #(.CHANNELS(4), .WIDTH(W)) bus_a ();
    multi_rate_scaler_if #(.CHANNELS(3), .WIDTH(W)) bus_b ();

    multi_rate_scaler #(.CHANNELS(4), .WIDTH(W)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    multi_rate_scaler #(.CHANNELS(3), .WIDTH(W)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] out;
        logic [3:0] tick;
    } exp_t;

    typedef struct {
        int         ch;
        logic [1:0] mode;
        int         div;
        int         duty;
        int         cycles;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    logic [1:0] sm[4];
    int         sd[4];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_out(input logic [1:0] mode, input int div, input int duty, input int k);
        int p = div + 1;
        case (mode)
            MODE_TOGGLE: return ((k / p) % 2) == 1;
            MODE_STROBE: return (k % p) == 0;
            MODE_PWM:    return (k % p) < duty;
            default:     return k == p;
        endcase
    endfunction

    function automatic logic exp_tick(input logic [1:0] mode, input int div, input int k);
        if (mode == MODE_ONESHOT) return k == div + 1;
        return (k % (div + 1)) == 0;
    endfunction

    function automatic exp_t exp_vec(input int k);
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            e.out[c]  = exp_out(sm[c], sd[c], 0, k);
            e.tick[c] = exp_tick(sm[c], sd[c], k);
        end
        return e;
    endfunction

    task automatic push_exp(input logic [3:0] o, input logic [3:0] t);
        exp_t e;
        e.out  = o;
        e.tick = t;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check4({name, " out"}, bus_a.out, e.out);
            check4({name, " tick"}, bus_a.tick, e.tick);
        end
    endtask

    task automatic cfg_write_a(input int ch, input logic [1:0] mode, input int div, input int duty);
        bus_a.cfg_ch   = 2'(ch);
        bus_a.cfg_mode = mode;
        bus_a.cfg_div  = W'(div);
        bus_a.cfg_duty = W'(duty);
        bus_a.cfg_we   = 1'b1;
        step();
        bus_a.cfg_we   = 1'b0;
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic [3:0] o, t;

        bus_a.en = '0; bus_a.sync = 1'b0; bus_a.cfg_we = 1'b0; bus_a.cfg_ch = '0;
        bus_a.cfg_mode = MODE_TOGGLE; bus_a.cfg_div = '0; bus_a.cfg_duty = '0;
        bus_b.en = '0; bus_b.sync = 1'b0; bus_b.cfg_we = 1'b0; bus_b.cfg_ch = '0;
        bus_b.cfg_mode = MODE_TOGGLE; bus_b.cfg_div = '0; bus_b.cfg_duty = '0;

        vecs[0] = '{0, MODE_TOGGLE,  3, 0,  20};
        vecs[1] = '{1, MODE_PWM,     9, 3,  30};
        vecs[2] = '{1, MODE_PWM,     9, 0,  20};
        vecs[3] = '{1, MODE_PWM,     9, 12, 20};
        vecs[4] = '{2, MODE_STROBE,  0, 0,  5};
        vecs[5] = '{0, MODE_TOGGLE,  0, 0,  6};
        vecs[6] = '{3, MODE_ONESHOT, 5, 0,  20};
        vecs[7] = '{3, MODE_ONESHOT, 5, 0,  14};
        vecs[8] = '{2, MODE_STROBE,  4, 0,  15};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check4("reset a out", bus_a.out, 4'b0);
        check4("reset a tick", bus_a.tick, 4'b0);
        check4("reset b out", {1'b0, bus_b.out}, 4'b0);
        rst = 1'b0;
        step();

        // Table-driven single-channel waveforms
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            bus_a.en = '0;
            cfg_write_a(v.ch, v.mode, v.div, v.duty);
            step();
            bus_a.en[v.ch] = 1'b1;
            for (int k = 1; k <= v.cycles; k++) begin
                o = '0;
                t = '0;
                o[v.ch] = exp_out(v.mode, v.div, v.duty, k);
                t[v.ch] = exp_tick(v.mode, v.div, k);
                push_exp(o, t);
                step();
                pop_cmp($sformatf("vec%0d k%0d", i, k));
            end
            bus_a.en = '0;
            step();
        end

        // Divisor change mid-period on a running channel
        cfg_write_a(2, MODE_STROBE, 7, 0);
        step();
        bus_a.en[2] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            t = '0;
            t[2] = (k == 8) || (k > 8 && ((k - 8) % 2) == 0);
            push_exp(t, t);
            if (k == 4) begin
                bus_a.cfg_ch = 2'd2; bus_a.cfg_mode = MODE_STROBE;
                bus_a.cfg_div = W'(1); bus_a.cfg_we = 1'b1;
            end
            step();
            bus_a.cfg_we = 1'b0;
            pop_cmp($sformatf("middiv k%0d", k));
        end
        bus_a.en = '0;
        step();

        // sync on a ch0 wrap cycle
        sm[0] = MODE_STROBE; sd[0] = 3;
        sm[1] = MODE_STROBE; sd[1] = 5;
        sm[2] = MODE_TOGGLE; sd[2] = 2;
        sm[3] = MODE_STROBE; sd[3] = 3;
        for (int c = 0; c < 4; c++) cfg_write_a(c, sm[c], sd[c], 0);
        step();
        bus_a.en = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            e = exp_vec(k);
            push_exp(e.out, e.tick);
            step();
            pop_cmp($sformatf("presync k%0d", k));
        end
        bus_a.sync = 1'b1;
        push_exp(4'b0, 4'b0);
        step();
        bus_a.sync = 1'b0;
        pop_cmp("sync edge");
        for (int m = 1; m <= 12; m++) begin
            e = exp_vec(m);
            push_exp(e.out, e.tick);
            step();
            pop_cmp($sformatf("postsync m%0d", m));
        end
        bus_a.en = '0;
        step();

        // Out-of-range channel select on the 3-channel instance
        bus_b.cfg_ch = 2'd3; bus_b.cfg_mode = MODE_STROBE; bus_b.cfg_div = W'(1);
        bus_b.cfg_we = 1'b1;
        step();
        bus_b.cfg_we = 1'b0;
        step();
        bus_b.en = 3'b111;
        for (int k = 1; k <= 6; k++) begin
            step();
            check4($sformatf("oor out k%0d", k), {1'b0, bus_b.out}, 4'b0);
            check4($sformatf("oor tick k%0d", k), {1'b0, bus_b.tick}, 4'b0);
        end
        bus_b.en = '0;
        bus_b.cfg_ch = 2'd2;
        bus_b.cfg_we = 1'b1;
        step();
        bus_b.cfg_we = 1'b0;
        step();
        bus_b.en = 3'b100;
        for (int k = 1; k <= 6; k++) begin
            step();
            t = ((k % 2) == 0) ? 4'b0100 : 4'b0000;
            check4($sformatf("inrange tick k%0d", k), {1'b0, bus_b.tick}, t);
        end

        // Asynchronous reset mid-run
        cfg_write_a(2, MODE_STROBE, 0, 0);
        step();
        bus_a.en[2] = 1'b1;
        step();
        step();
        check4("prerst out", bus_a.out, 4'b0100);
        check4("prerst tick", bus_a.tick, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check4("async rst a out", bus_a.out, 4'b0);
        check4("async rst a tick", bus_a.tick, 4'b0);
        check4("async rst b tick", {1'b0, bus_b.tick}, 4'b0);
        step();
        rst = 1'b0;
        bus_a.en = '0;
        bus_b.en = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
